// File: rtl/tmds_pkg.sv
// Shared types, control-token table and popcount helper for the TMDS encoder lane.
package tmds_pkg;

    typedef logic [9:0] tmds_sym_t;
    typedef logic [8:0] tmds_qm_t;

    // Indexed by {c1,c0}.
    localparam tmds_sym_t CTRL_TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_if.sv
// Video-side lane bundle: timing generator drives de/d/c, encoder returns the 10-bit symbol.
interface tmds_if;
    import tmds_pkg::*;

    logic       de;
    logic [7:0] d;
    logic [1:0] c;
    tmds_sym_t  q;

    modport master (output de, d, c, input q);
    modport slave  (input de, d, c, output q);

endinterface

// File: rtl/tmds_stage1.sv
// First pipeline stage: transition-minimizing XOR/XNOR chain plus ones count of the result.
module tmds_stage1
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       arst_n,
    input  logic       de,
    input  logic [7:0] d,
    input  logic [1:0] c,
    output tmds_qm_t   qm_p1,
    output logic [3:0] n1q_p1,
    output logic       de_p1,
    output logic [1:0] c_p1
);

    logic [3:0] n1d;
    logic       use_xnor;
    tmds_qm_t   qm;

    always_comb begin
        n1d      = popcnt8(d);
        // Ties broken on d[0] so the choice is deterministic for balanced bytes.
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8]    = ~use_xnor;
    end

    // ---- stage 1 register boundary ----
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            qm_p1  <= '0;
            n1q_p1 <= '0;
            de_p1  <= 1'b0;
            c_p1   <= 2'b00;
        end else begin
            qm_p1  <= qm;
            n1q_p1 <= popcnt8(qm[7:0]);
            de_p1  <= de;
            c_p1   <= c;
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// DVI TMDS 8b/10b lane encoder: two-stage pipeline, running-disparity DC balance, control tokens.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int CNT_W = 5
)
(
    input  logic  clk,
    input  logic  arst_n,
    tmds_if.slave bus
);

    localparam logic signed [CNT_W-1:0] ZERO  = '0;
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

    tmds_qm_t                qm_p1;
    logic [3:0]              n1q_p1;
    logic                    de_p1;
    logic [1:0]              c_p1;

    tmds_sym_t               q_p2;
    logic signed [CNT_W-1:0] cnt_p2;

    tmds_sym_t               q_nxt;
    logic signed [CNT_W-1:0] cnt_nxt;
    logic signed [CNT_W-1:0] n1q_s;
    logic signed [CNT_W-1:0] n0q_s;
    logic signed [CNT_W-1:0] diff;

    tmds_stage1 u_stage1 (
        .clk    (clk),
        .arst_n (arst_n),
        .de     (bus.de),
        .d      (bus.d),
        .c      (bus.c),
        .qm_p1  (qm_p1),
        .n1q_p1 (n1q_p1),
        .de_p1  (de_p1),
        .c_p1   (c_p1)
    );

    always_comb begin
        n1q_s   = signed'(CNT_W'(n1q_p1));
        n0q_s   = EIGHT - n1q_s;
        diff    = n1q_s - n0q_s;
        q_nxt   = q_p2;
        cnt_nxt = cnt_p2;
        if (!de_p1) begin
            // Clearing disparity here makes every burst start balanced.
            q_nxt   = CTRL_TOK[c_p1];
            cnt_nxt = ZERO;
        end else if ((cnt_p2 == ZERO) || (n1q_p1 == 4'd4)) begin
            q_nxt   = {~qm_p1[8], qm_p1[8], qm_p1[8] ? qm_p1[7:0] : ~qm_p1[7:0]};
            cnt_nxt = qm_p1[8] ? (cnt_p2 + diff) : (cnt_p2 - diff);
        end else if (((cnt_p2 > ZERO) && (n1q_s > n0q_s)) ||
                     ((cnt_p2 < ZERO) && (n0q_s > n1q_s))) begin
            q_nxt   = {1'b1, qm_p1[8], ~qm_p1[7:0]};
            cnt_nxt = cnt_p2 + (qm_p1[8] ? TWO : ZERO) - diff;
        end else begin
            q_nxt   = {1'b0, qm_p1[8], qm_p1[7:0]};
            cnt_nxt = cnt_p2 - (qm_p1[8] ? ZERO : TWO) + diff;
        end
    end

    // ---- stage 2 register boundary ----
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q_p2   <= CTRL_TOK[0];
            cnt_p2 <= ZERO;
        end else begin
            q_p2   <= q_nxt;
            cnt_p2 <= cnt_nxt;
        end
    end

    assign bus.q = q_p2;

endmodule
